// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scan sequencer with a programmable tick prescaler.
// Inputs are shadowed once per frame so a frame is never torn by mid-scan updates.
module display_scan_controller #(
  parameter int DIGITS      = 4,
  parameter int DIV_W       = 16,
  parameter int BLANK_TICKS = 1,
  parameter int DRIVE_TICKS = 2
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           refresh_div,
  input  logic [4*DIGITS-1:0]        digits,
  input  logic [DIGITS-1:0]          dp_mask,
  output logic [DIGITS-1:0]          an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [$clog2(DIGITS)-1:0]  scan_idx,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int unsigned IW        = $clog2(DIGITS);
  localparam int          MAX_TICKS = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
  localparam int unsigned TW        = $clog2(MAX_TICKS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} state_t;

  localparam state_t FIRST_ST = (BLANK_TICKS > 0) ? BLANK : DRIVE;

  state_t                state, state_n;
  logic [DIV_W-1:0]      cnt, cnt_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [DIV_W-1:0]      div_sh;
  logic [4*DIGITS-1:0]   digits_sh;
  logic [DIGITS-1:0]     dp_sh;
  logic [IW-1:0]         idx_n;
  logic                  fd_n;
  logic                  tick_c;
  logic                  last_blank_c;
  logic                  last_drive_c;
  logic [3:0]            nib_c;
  logic [DIGITS-1:0]     an_n;
  logic [6:0]            seg_n;
  logic                  dp_n;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // State register, counters, shadows and registered outputs
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      div_sh     <= '0;
      digits_sh  <= '0;
      dp_sh      <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      scan_idx   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tcnt       <= tcnt_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
      scan_idx   <= idx_n;
      busy       <= (state_n != IDLE);
      frame_done <= fd_n;
      // Capture on the edge entering LOAD so shadows are valid for the first digit
      if (state_n == LOAD) begin
        div_sh    <= refresh_div;
        digits_sh <= digits;
        dp_sh     <= dp_mask;
      end
    end
  end

  // Next state, counters and next output values
  always_comb begin
    state_n      = state;
    idx_n        = scan_idx;
    cnt_n        = '0;
    tcnt_n       = '0;
    fd_n         = 1'b0;
    tick_c       = (cnt == div_sh);
    last_blank_c = (32'(tcnt) == 32'(BLANK_TICKS - 1));
    last_drive_c = (32'(tcnt) == 32'(DRIVE_TICKS - 1));

    case (state)
      IDLE: begin
        if (enable) state_n = LOAD;
      end
      LOAD: begin
        if (!enable) state_n = IDLE;
        else         state_n = FIRST_ST;
      end
      BLANK: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (tick_c && last_blank_c) begin
          state_n = DRIVE;
        end else if (tick_c) begin
          tcnt_n = tcnt + TW'(1);
        end else begin
          cnt_n  = cnt + DIV_W'(1);
          tcnt_n = tcnt;
        end
      end
      DRIVE: begin
        // A completed frame takes precedence over a late enable drop
        if (tick_c && last_drive_c && (scan_idx == IW'(DIGITS - 1))) begin
          fd_n    = 1'b1;
          state_n = enable ? LOAD : IDLE;
        end else if (!enable) begin
          state_n = IDLE;
        end else if (tick_c && last_drive_c) begin
          idx_n   = scan_idx + IW'(1);
          state_n = FIRST_ST;
        end else if (tick_c) begin
          tcnt_n = tcnt + TW'(1);
        end else begin
          cnt_n  = cnt + DIV_W'(1);
          tcnt_n = tcnt;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == IDLE || state_n == LOAD) idx_n = '0;

    nib_c = 4'(digits_sh >> {idx_n, 2'b00});
    an_n  = '1;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (state_n == DRIVE) begin
      an_n  = ~(DIGITS'(1) << idx_n);
      seg_n = hex7(nib_c);
      dp_n  = ~dp_sh[idx_n];
    end
  end

endmodule
